hps_reset_req_ctrl: RTL and testbench

HPS_RESET_REQ_CTRL -- requirements
Module: hps_reset_req_ctrl

---
 rtl/hps_rst_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 71 +++++++
 rtl/hps_reset_req_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hps_reset_req_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hps_rst_pkg
// Description : Shared types and sizing helpers for the HPS reset-request block.
// Revision    : 1.0 - initial release
// ============================================================================
package hps_rst_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TIMING   = 3'd1,
        REQ      = 3'd2,
        WAIT_ACK = 3'd3,
        LOCKOUT  = 3'd4
    } hps_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        WARM  = 2'd1,
        COLD  = 2'd2,
        DEBUG = 2'd3
    } req_kind_t;

    localparam int c_REQ_COUNT_W = 8;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchronizer plus stability counter for one active-low
//               push button; emits a level and a one-cycle press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import hps_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button_n,
    output logic o_pressed,
    output logic o_press_edge
);

    localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_armed;
    logic               r_press_edge;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_raw_pressed;
    logic               w_differs;
    logic               w_settled;

    assign w_raw_pressed = ~r_sync2;
    assign w_differs     = (w_raw_pressed != r_level);
    assign w_settled     = w_differs && (r_cnt == c_CNT_LAST);

    // Sync flops clear to 0, which reads as "pressed": a press edge is only
    // armed once a genuine release has been seen, so a button held through
    // reset must be let go and pressed again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_level      <= 1'b0;
            r_armed      <= 1'b0;
            r_press_edge <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync1      <= i_button_n;
            r_sync2      <= r_sync1;
            r_press_edge <= 1'b0;
            if (r_sync2) begin
                r_armed <= 1'b1;
            end
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_cnt        <= '0;
                r_level      <= w_raw_pressed;
                r_press_edge <= w_raw_pressed & r_armed;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_pressed    = r_level;
    assign o_press_edge = r_press_edge;

endmodule
`default_nettype wire

// File: rtl/hps_reset_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hps_reset_req_ctrl
// Description : Turns debounced push-button presses into warm/cold/debug HPS
//               reset-request pulses and tracks the HPS acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module hps_reset_req_ctrl
    import hps_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int PULSE_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [1:0]               button_n,
    input  logic                     h2f_reset_n,
    output logic                     f2h_cold_req_n,
    output logic                     f2h_warm_req_n,
    output logic                     f2h_debug_req_n,
    output logic                     busy,
    output logic                     timeout_flag,
    output logic [c_REQ_COUNT_W-1:0] req_count
);

    localparam int                   c_DUR_W     = cnt_width(LONG_CYCLES);
    localparam int                   c_PULSE_W   = cnt_width(PULSE_CYCLES);
    localparam int                   c_TMO_W     = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_DUR_W-1:0]   c_DUR_LAST   = c_DUR_W'(LONG_CYCLES - 1);
    localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]               w_pressed;
    logic [1:0]               w_press_edge;
    logic                     r_h2f_sync1;
    logic                     r_h2f_sync2;
    hps_state_t               r_state,     w_state_nxt;
    req_kind_t                r_kind,      w_kind_nxt;
    logic [c_DUR_W-1:0]       r_dur_cnt,   w_dur_cnt_nxt;
    logic [c_PULSE_W-1:0]     r_pulse_cnt, w_pulse_cnt_nxt;
    logic [c_TMO_W-1:0]       r_tmo_cnt,   w_tmo_cnt_nxt;
    logic                     r_ack_low,   w_ack_low_nxt;
    logic                     r_timeout,   w_timeout_nxt;
    logic [c_REQ_COUNT_W-1:0] r_req_count;
    logic                     r_cold_n;
    logic                     r_warm_n;
    logic                     r_debug_n;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk          (clk_clk),
                .rst_n        (reset_reset_n),
                .i_button_n   (button_n[gi]),
                .o_pressed    (w_pressed[gi]),
                .o_press_edge (w_press_edge[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_h2f_sync1 <= 1'b0;
            r_h2f_sync2 <= 1'b0;
            r_state     <= IDLE;
            r_kind      <= NONE;
            r_dur_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_ack_low   <= 1'b0;
            r_timeout   <= 1'b0;
            r_req_count <= '0;
            r_cold_n    <= 1'b1;
            r_warm_n    <= 1'b1;
            r_debug_n   <= 1'b1;
        end else begin
            r_h2f_sync1 <= h2f_reset_n;
            r_h2f_sync2 <= r_h2f_sync1;
            r_state     <= w_state_nxt;
            r_kind      <= w_kind_nxt;
            r_dur_cnt   <= w_dur_cnt_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_ack_low   <= w_ack_low_nxt;
            r_timeout   <= w_timeout_nxt;
            if ((w_state_nxt == REQ) && (r_state != REQ)) begin
                r_req_count <= r_req_count + c_REQ_COUNT_W'(1);
            end
            // Request outputs follow the next state so each is low exactly
            // while the registered state is REQ.
            r_cold_n  <= !((w_state_nxt == REQ) && (w_kind_nxt == COLD));
            r_warm_n  <= !((w_state_nxt == REQ) && (w_kind_nxt == WARM));
            r_debug_n <= !((w_state_nxt == REQ) && (w_kind_nxt == DEBUG));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_kind_nxt      = r_kind;
        w_dur_cnt_nxt   = r_dur_cnt;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_ack_low_nxt   = r_ack_low;
        w_timeout_nxt   = r_timeout;
        case (r_state)
            IDLE: begin
                w_kind_nxt = NONE;
                if (r_h2f_sync2 && w_press_edge[0]) begin
                    w_state_nxt   = TIMING;
                    w_dur_cnt_nxt = '0;
                end else if (r_h2f_sync2 && w_press_edge[1]) begin
                    w_state_nxt     = REQ;
                    w_kind_nxt      = DEBUG;
                    w_pulse_cnt_nxt = '0;
                end
            end
            TIMING: begin
                if (!w_pressed[0]) begin
                    w_state_nxt     = REQ;
                    w_kind_nxt      = WARM;
                    w_pulse_cnt_nxt = '0;
                end else if (r_dur_cnt == c_DUR_LAST) begin
                    w_state_nxt     = REQ;
                    w_kind_nxt      = COLD;
                    w_pulse_cnt_nxt = '0;
                end else begin
                    w_dur_cnt_nxt = r_dur_cnt + c_DUR_W'(1);
                end
            end
            REQ: begin
                if (r_pulse_cnt == c_PULSE_LAST) begin
                    w_state_nxt   = WAIT_ACK;
                    w_kind_nxt    = NONE;
                    w_tmo_cnt_nxt = '0;
                    w_ack_low_nxt = 1'b0;
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt + c_PULSE_W'(1);
                end
            end
            WAIT_ACK: begin
                if (!r_h2f_sync2) begin
                    w_ack_low_nxt = 1'b1;
                end
                if (r_ack_low && r_h2f_sync2) begin
                    w_state_nxt = LOCKOUT;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_state_nxt   = LOCKOUT;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + c_TMO_W'(1);
                end
            end
            LOCKOUT: begin
                w_kind_nxt = NONE;
                if (w_pressed == 2'b00) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_kind_nxt  = NONE;
            end
        endcase
    end

    assign f2h_cold_req_n  = r_cold_n;
    assign f2h_warm_req_n  = r_warm_n;
    assign f2h_debug_req_n = r_debug_n;
    assign busy            = (r_state != IDLE);
    assign timeout_flag    = r_timeout;
    assign req_count       = r_req_count;

endmodule
`default_nettype wire

// File: tb/tb_hps_reset_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hps_reset_req_ctrl
// Description : Directed self-checking bench for hps_reset_req_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_reset_req_ctrl;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [1:0] button_n;
    logic       h2f_reset_n;
    logic       f2h_cold_req_n;
    logic       f2h_warm_req_n;
    logic       f2h_debug_req_n;
    logic       busy;
    logic       timeout_flag;
    logic [7:0] req_count;

    int errors = 0;
    int checks = 0;
    int n_warm = 0;
    int n_cold = 0;
    int n_dbg  = 0;

    always #5 clk_clk = ~clk_clk;

    hps_reset_req_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .PULSE_CYCLES    (3),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .button_n        (button_n),
        .h2f_reset_n     (h2f_reset_n),
        .f2h_cold_req_n  (f2h_cold_req_n),
        .f2h_warm_req_n  (f2h_warm_req_n),
        .f2h_debug_req_n (f2h_debug_req_n),
        .busy            (busy),
        .timeout_flag    (timeout_flag),
        .req_count       (req_count)
    );

    // One clock; outputs are sampled 1 time unit after the edge and low
    // request outputs are tallied per cycle.
    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (f2h_warm_req_n === 1'b0)  n_warm++;
        if (f2h_cold_req_n === 1'b0)  n_cold++;
        if (f2h_debug_req_n === 1'b0) n_dbg++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        n_warm = 0;
        n_cold = 0;
        n_dbg  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int b, input int hold);
        button_n[b] = 1'b0;
        ticks(hold);
        button_n[b] = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (f2h_warm_req_n && f2h_cold_req_n && f2h_debug_req_n && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_req_seen"}, 32'(k < 100), 32'd1);
    endtask

    // Acknowledge pulse on h2f_reset_n, issued 5 cycles after the request.
    task automatic ack();
        ticks(4);
        h2f_reset_n = 1'b0;
        ticks(5);
        h2f_reset_n = 1'b1;
        ticks(12);
    endtask

    initial begin
        int c;
        reset_reset_n = 1'b0;
        button_n      = 2'b11;
        h2f_reset_n   = 1'b1;
        ticks(3);
        check("rst_warm",  32'(f2h_warm_req_n), 32'd1);
        check("rst_cold",  32'(f2h_cold_req_n), 32'd1);
        check("rst_dbg",   32'(f2h_debug_req_n), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_tmo",   32'(timeout_flag), 32'd0);
        check("rst_count", 32'(req_count), 32'd0);
        reset_reset_n = 1'b1;
        ticks(5);

        // Short press -> warm
        clear_counts();
        press(0, 10);
        wait_req("short");
        check("short_busy", 32'(busy), 32'd1);
        ack();
        check("short_warm_w", 32'(n_warm), 32'd3);
        check("short_cold_w", 32'(n_cold), 32'd0);
        check("short_dbg_w",  32'(n_dbg), 32'd0);
        check("short_count",  32'(req_count), 32'd1);
        check("short_idle",   32'(busy), 32'd0);

        // Long press -> cold while held, lockout until release
        clear_counts();
        button_n[0] = 1'b0;
        ticks(30);
        check("long_cold_w", 32'(n_cold), 32'd3);
        check("long_warm_w", 32'(n_warm), 32'd0);
        check("long_held",   32'(f2h_cold_req_n), 32'd1);
        h2f_reset_n = 1'b0;
        ticks(5);
        h2f_reset_n = 1'b1;
        ticks(5);
        check("long_lockout", 32'(busy), 32'd1);
        check("long_tmo",     32'(timeout_flag), 32'd0);
        button_n[0] = 1'b1;
        ticks(12);
        check("long_idle",   32'(busy), 32'd0);
        check("long_count",  32'(req_count), 32'd2);
        check("long_warm_2", 32'(n_warm), 32'd0);

        // Glitch on button 1 is rejected
        clear_counts();
        press(1, 3);
        ticks(15);
        check("glitch_dbg",   32'(n_dbg), 32'd0);
        check("glitch_busy",  32'(busy), 32'd0);
        check("glitch_count", 32'(req_count), 32'd2);

        // Simultaneous press: button 0 wins, debug never asserted
        clear_counts();
        button_n = 2'b00;
        ticks(10);
        button_n = 2'b11;
        wait_req("both");
        ack();
        check("both_warm",  32'(n_warm), 32'd3);
        check("both_cold",  32'(n_cold), 32'd0);
        check("both_dbg",   32'(n_dbg), 32'd0);
        check("both_count", 32'(req_count), 32'd3);
        check("both_idle",  32'(busy), 32'd0);

        // No acknowledge -> timeout 50 cycles after the pulse ends
        clear_counts();
        press(0, 10);
        wait_req("tmo");
        ticks(3);
        check("tmo_pulse", 32'(n_warm), 32'd3);
        check("tmo_pre",   32'(timeout_flag), 32'd0);
        c = 0;
        while (!timeout_flag && c < 100) begin
            tick();
            c++;
        end
        check("tmo_cycles",  32'(c), 32'd50);
        check("tmo_lockout", 32'(busy), 32'd1);
        ticks(3);
        check("tmo_idle", 32'(busy), 32'd0);
        press(1, 8);
        wait_req("after_tmo");
        ack();
        check("tmo_sticky",    32'(timeout_flag), 32'd1);
        check("tmo_count",     32'(req_count), 32'd5);

        // Reset on the 2nd REQ cycle with button 1 held through reset
        clear_counts();
        button_n[1] = 1'b0;
        wait_req("midrst");
        tick();
        reset_reset_n = 1'b0;
        tick();
        check("midrst_warm",  32'(f2h_warm_req_n), 32'd1);
        check("midrst_cold",  32'(f2h_cold_req_n), 32'd1);
        check("midrst_dbg",   32'(f2h_debug_req_n), 32'd1);
        check("midrst_count", 32'(req_count), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_tmo",   32'(timeout_flag), 32'd0);
        reset_reset_n = 1'b1;
        clear_counts();
        ticks(30);
        check("held_dbg",   32'(n_dbg), 32'd0);
        check("held_count", 32'(req_count), 32'd0);
        check("held_busy",  32'(busy), 32'd0);
        button_n[1] = 1'b1;
        ticks(10);
        press(1, 8);
        wait_req("repress");
        ack();
        check("repress_dbg",   32'(n_dbg), 32'd3);
        check("repress_count", 32'(req_count), 32'd1);

        // 255 more requests wrap req_count to 0
        for (int i = 0; i < 255; i++) begin
            press(1, 8);
            wait_req("wrap");
            ack();
        end
        check("wrap_count", 32'(req_count), 32'd0);

        // Press while h2f_reset_n is low is discarded, not queued
        h2f_reset_n = 1'b0;
        ticks(5);
        clear_counts();
        press(1, 8);
        ticks(20);
        check("inhibit_dbg",   32'(n_dbg), 32'd0);
        check("inhibit_busy",  32'(busy), 32'd0);
        h2f_reset_n = 1'b1;
        ticks(10);
        check("inhibit_queue", 32'(busy), 32'd0);
        check("inhibit_count", 32'(req_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
